addr_seq_counter: RTL and testbench
===================================

# addr_seq_counter

Parametrised address sequencer for the online multiplier's digit buffers; successor to the single-width write-address counter. Generates a WIDTH-bit buffer address advancing on qualified writes, with up/down direction, synchronous load, terminal-count detection and a settable end-of-range policy. Sits between the digit-serial datapath controller and the operand/result RAMs, one instance per buffer port.

## Interface
- WIDTH, 9: address width in bits.
- DEPTH, 512: buffer depth. The highest address is DEPTH-1. Elaboration error unless 2 <= DEPTH <= 2**WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  count qualifier.
- write_enable  in  1  write qualifier. An advance occurs only when enable && write_enable.
- dir  in  1  0 = count up, 1 = count down. Sampled at each advance.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value.
- cnt  out  WIDTH  current address, registered.
- tc  out  1  terminal count, combinational from cnt and dir: (dir==0 && cnt==DEPTH-1) || (dir==1 && cnt==0).
- done  out  1  high while in DONE.
- wrap  out  1  one-cycle registered pulse marking a wrap.

## Operation
- States: INIT, RUN, DONE.
- rst=1 at a clock edge:
  - state <= INIT, cnt <= 0, wrap <= 0.
  - This overrides all other inputs, including mid-count and in DONE.
- INIT: lasts exactly one cycle. All inputs are ignored and cnt stays 0, so the first and the -1 address cycles both read 0. Next state is RUN.
- RUN, priority order:
  1. load: cnt <= min(load_val, DEPTH-1), state stays RUN. A load and an advance in the same cycle resolve to the load, and the advance is dropped.
  2. advance when tc=0: cnt <= cnt+1 (dir=0) or cnt-1 (dir=1).
  3. advance when tc=1: end-of-range policy; see Configuration.
  4. Otherwise cnt holds.
- DONE: cnt holds and advances are ignored. Only load or rst leaves DONE; load returns to RUN with the clipped value.
- Arithmetic is modulo 2**WIDTH internally. The result is never allowed outside 0..DEPTH-1.
- wrap is 0 in every cycle except the one following a wrap advance.

## Timing
- cnt changes on the clock edge that samples the advance or load, so there is one cycle of latency from input to cnt.
- tc follows cnt and dir in the same cycle, with no added latency.
- done rises in the cycle after the terminal advance that causes entry to DONE.
- wrap is high for exactly one cycle, the cycle after the wrap advance, aligned with the wrapped cnt.
- The first cycle after rst falls is INIT. The earliest cnt change is visible 2 cycles after rst deasserts.
- Reset values: cnt=0, done=0, wrap=0. tc = (dir==1), because cnt=0.

## Configuration
- Macro: ADDR_SEQ_WRAP_EN.
- Defined: an advance at tc=1 wraps.
  - Up: cnt <= 0. Down: cnt <= DEPTH-1.
  - wrap pulses and the state stays RUN.
  - DONE is unreachable and done is tied 0.
- Undefined: an advance at tc=1 leaves cnt unchanged and state <= DONE.
  - wrap is tied 0.

## Structure
- Shared package addr_seq_pkg holds:
  - the state enum (INIT, RUN, DONE);
  - DIR_UP/DIR_DOWN constants;
  - a function clip_addr(value, depth) used by the load path.
- One sub-module: addr_seq_next. It is combinational and computes the next address plus the wrap/terminal decision from cnt, dir and DEPTH. It is reused by the read-side sequencer. The top level holds the state register and output registers.

## Test plan
- Reset release, enable=write_enable=1, dir=0 → cnt reads 0,0,1,2 on successive cycles from the first post-reset cycle; done=0, wrap=0.
- DEPTH=4, wrap undefined, up count from 0 with continuous advance:
  - cnt 1,2,3, then holds at 3; tc=1 at 3; done=1 one cycle later.
  - Further advances keep cnt=3.
  - load with load_val=1 → cnt=1, done=0.
- DEPTH=4, ADDR_SEQ_WRAP_EN, continuous advance:
  - up: cnt 1,2,3,0,1; wrap=1 only in the cycle cnt returns to 0.
  - dir=1 from 0 → cnt=3 with a wrap pulse.
- load with load_val=600 while advancing, WIDTH=10, DEPTH=512 → cnt=511, the advance is dropped, tc=1 for dir=0.
- enable=1, write_enable=0 for 5 cycles → cnt unchanged. Then toggle dir mid-stream → the count reverses on the next advance.
- rst asserted in DONE and mid-count at cnt=200 → next cycle cnt=0, state INIT, done=0. One cycle of INIT ignores load and advance.

Source files
------------

// File: rtl/addr_seq_pkg.sv
// Shared types and helpers for the digit-buffer address sequencers.
// Consumers: addr_seq_next, addr_seq_counter and the read-side sequencer.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Loads may carry any WIDTH-bit value; anything past the buffer end pins to the last address.
    function automatic int unsigned clip_addr(input int unsigned value, input int unsigned depth);
        return (value > depth - 1) ? depth - 1 : value;
    endfunction

endpackage

// File: rtl/addr_seq_counter_if.sv
// Control/status bundle between the datapath controller (master) and one
// address sequencer (slave).
interface addr_seq_counter_if #(
    parameter int WIDTH = 9
);
    logic             enable;
    logic             write_enable;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             done;
    logic             wrap;

    modport master (
        output enable, write_enable, dir, load, load_val,
        input  cnt, tc, done, wrap
    );

    modport slave (
        input  enable, write_enable, dir, load, load_val,
        output cnt, tc, done, wrap
    );
endinterface

// File: rtl/addr_seq_next.sv
// Combinational next-address step: terminal detection and the address that
// follows an advance, including the wrap target when already at the range end.
module addr_seq_next
    import addr_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 512
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             dir,
    output logic [WIDTH-1:0] next_cnt,
    output logic             at_tc
);
    localparam logic [WIDTH-1:0] MAX_ADDR = WIDTH'(DEPTH - 1);

    always_comb begin
        at_tc    = 1'b0;
        next_cnt = cnt;
        if (dir == DIR_DOWN) begin
            at_tc    = (cnt == '0);
            next_cnt = at_tc ? MAX_ADDR : cnt - WIDTH'(1);
        end else begin
            at_tc    = (cnt == MAX_ADDR);
            next_cnt = at_tc ? '0 : cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/addr_seq_counter.sv
// Write-side buffer address sequencer: INIT/RUN/DONE control around addr_seq_next.
// Define ADDR_SEQ_WRAP_EN to wrap at the range end instead of stopping in DONE.
module addr_seq_counter
    import addr_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 512
) (
    input  logic               clk,
    input  logic               rst,
    addr_seq_counter_if.slave  bus
);
    if ((DEPTH < 2) || (64'(DEPTH) > (64'd1 << WIDTH))) begin : g_bad_depth
        $error("addr_seq_counter: DEPTH must satisfy 2 <= DEPTH <= 2**WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] next_cnt;
    logic             at_tc;
    logic [WIDTH-1:0] load_clip;
    logic             advance;

    addr_seq_next #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_next (
        .cnt      (cnt_q),
        .dir      (bus.dir),
        .next_cnt (next_cnt),
        .at_tc    (at_tc)
    );

    assign advance   = bus.enable && bus.write_enable;
    assign load_clip = WIDTH'(clip_addr(32'(bus.load_val), DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            // One dead cycle after reset so the first two address cycles both read 0.
            ST_INIT: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (bus.load) begin
                    cnt_d = load_clip;
                end else if (advance) begin
                    if (!at_tc) begin
                        cnt_d = next_cnt;
                    end else begin
`ifdef ADDR_SEQ_WRAP_EN
                        cnt_d  = next_cnt;
                        wrap_d = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (bus.load) begin
                    cnt_d   = load_clip;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.tc   = at_tc;
    assign bus.wrap = wrap_q;
`ifdef ADDR_SEQ_WRAP_EN
    assign bus.done = 1'b0;
`else
    assign bus.done = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_addr_seq_counter.sv
// Bench for addr_seq_counter: a DEPTH=4 and a WIDTH=10/DEPTH=512 instance run
// side by side against a behavioural model; directed steps then random traffic.
module tb_addr_seq_counter;

`ifdef ADDR_SEQ_WRAP_EN
    localparam bit WRAP_MODE = 1'b1;
`else
    localparam bit WRAP_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, we, dir, load;
    logic [2:0] lv_s;
    logic [9:0] lv_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    addr_seq_counter_if #(.WIDTH(3))  if_s ();
    addr_seq_counter_if #(.WIDTH(10)) if_b ();

    assign if_s.enable       = en;
    assign if_s.write_enable = we;
    assign if_s.dir          = dir;
    assign if_s.load         = load;
    assign if_s.load_val     = lv_s;
    assign if_b.enable       = en;
    assign if_b.write_enable = we;
    assign if_b.dir          = dir;
    assign if_b.load         = load;
    assign if_b.load_val     = lv_b;

    addr_seq_counter #(.WIDTH(3), .DEPTH(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    addr_seq_counter #(.WIDTH(10), .DEPTH(512)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 = DEPTH 4 instance, index 1 = DEPTH 512 instance.
    int m_cnt  [2];
    bit m_init [2];
    bit m_stop [2];
    bit m_wrap [2];
    int depth  [2] = '{4, 512};

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int lv;
            bit term;
            lv = (i == 0) ? int'(lv_s) : int'(lv_b);
            if (rst) begin
                m_cnt[i]  = 0;
                m_init[i] = 1'b1;
                m_stop[i] = 1'b0;
                m_wrap[i] = 1'b0;
            end else if (m_init[i]) begin
                m_init[i] = 1'b0;
                m_wrap[i] = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                if (load) begin
                    m_cnt[i]  = (lv < depth[i]) ? lv : depth[i] - 1;
                    m_stop[i] = 1'b0;
                end else if (en && we && !m_stop[i]) begin
                    term = dir ? (m_cnt[i] == 0) : (m_cnt[i] == depth[i] - 1);
                    if (!term) begin
                        m_cnt[i] = dir ? m_cnt[i] - 1 : m_cnt[i] + 1;
                    end else if (WRAP_MODE) begin
                        m_cnt[i]  = dir ? depth[i] - 1 : 0;
                        m_wrap[i] = 1'b1;
                    end else begin
                        m_stop[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_tc(input int i);
        return dir ? int'(m_cnt[i] == 0) : int'(m_cnt[i] == depth[i] - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check("s_cnt",  32'(if_s.cnt),  m_cnt[0]);
        check("s_tc",   32'(if_s.tc),   exp_tc(0));
        check("s_done", 32'(if_s.done), 32'(m_stop[0]));
        check("s_wrap", 32'(if_s.wrap), 32'(m_wrap[0]));
        check("b_cnt",  32'(if_b.cnt),  m_cnt[1]);
        check("b_tc",   32'(if_b.tc),   exp_tc(1));
        check("b_done", 32'(if_b.done), 32'(m_stop[1]));
        check("b_wrap", 32'(if_b.wrap), 32'(m_wrap[1]));
        $display("cyc %0d rst=%b ld=%b en=%b we=%b dir=%b | s cnt=%0d tc=%b dn=%b wr=%b | b cnt=%0d tc=%b dn=%b wr=%b",
                 cyc, rst, load, en, we, dir, if_s.cnt, if_s.tc, if_s.done, if_s.wrap,
                 if_b.cnt, if_b.tc, if_b.done, if_b.wrap);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; we = 1'b1; dir = 1'b0; load = 1'b0;
        lv_s = '0; lv_b = '0;

        // Reset state, and tc follows dir while cnt is 0.
        tick();
        tick();
        check("rst_tc_up", 32'(if_b.tc), 0);
        dir = 1'b1;
        #1;
        check("rst_tc_down", 32'(if_b.tc), 1);
        dir = 1'b0;

        // Release with continuous up-advance: 0,0,1,2 from the first post-reset cycle.
        rst = 1'b0;
        check("rel_0", 32'(if_b.cnt), 0);
        tick(); check("rel_1", 32'(if_b.cnt), 0);
        tick(); check("rel_2", 32'(if_b.cnt), 1);
        check("rel_2_done", 32'(if_b.done), 0);
        tick(); check("rel_3", 32'(if_b.cnt), 2);

        // DEPTH=4 reaches its end and either wraps or stops.
        tick();
        check("s_at_max", 32'(if_s.cnt), 3);
        check("s_at_max_tc", 32'(if_s.tc), 1);
        tick();
        check("s_end_cnt",  32'(if_s.cnt),  WRAP_MODE ? 0 : 3);
        check("s_end_done", 32'(if_s.done), WRAP_MODE ? 0 : 1);
        check("s_end_wrap", 32'(if_s.wrap), WRAP_MODE ? 1 : 0);
        tick();
        check("s_after_cnt",  32'(if_s.cnt),  WRAP_MODE ? 1 : 3);
        check("s_after_wrap", 32'(if_s.wrap), 0);

        // Load leaves DONE.
        load = 1'b1; lv_s = 3'd1; lv_b = 10'd1;
        tick();
        load = 1'b0;
        check("s_load_cnt",  32'(if_s.cnt),  1);
        check("s_load_done", 32'(if_s.done), 0);

        // Down-advance from 0.
        load = 1'b1; lv_s = 3'd0;
        tick();
        load = 1'b0; dir = 1'b1;
        tick();
        check("s_down_cnt",  32'(if_s.cnt),  WRAP_MODE ? 3 : 0);
        check("s_down_wrap", 32'(if_s.wrap), WRAP_MODE ? 1 : 0);
        check("s_down_done", 32'(if_s.done), WRAP_MODE ? 0 : 1);

        // Oversized load with a simultaneous advance: clip wins, advance dropped.
        dir = 1'b0; load = 1'b1; lv_b = 10'd600; lv_s = 3'd7;
        tick();
        load = 1'b0;
        check("b_clip",    32'(if_b.cnt), 511);
        check("b_clip_tc", 32'(if_b.tc),  1);
        check("s_clip",    32'(if_s.cnt), 3);

        // write_enable low holds; dir flip reverses the count.
        we = 1'b0; dir = 1'b1;
        repeat (5) tick();
        check("b_hold", 32'(if_b.cnt), 511);
        we = 1'b1;
        tick(); check("b_rev_down", 32'(if_b.cnt), 510);
        dir = 1'b0;
        tick(); check("b_rev_up", 32'(if_b.cnt), 511);

        // Reset mid-count (big at 200) and with the small instance at its end.
        load = 1'b1; lv_b = 10'd201; lv_s = 3'd0; dir = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("b_pre_rst", 32'(if_b.cnt), 200);
        check("s_pre_rst_done", 32'(if_s.done), WRAP_MODE ? 0 : 1);
        rst = 1'b1;
        tick();
        check("b_rst_cnt",  32'(if_b.cnt),  0);
        check("s_rst_cnt",  32'(if_s.cnt),  0);
        check("s_rst_done", 32'(if_s.done), 0);

        // INIT ignores load and advance for one cycle.
        rst = 1'b0; load = 1'b1; lv_b = 10'd77; lv_s = 3'd2;
        tick();
        check("init_b", 32'(if_b.cnt), 0);
        check("init_s", 32'(if_s.cnt), 0);
        tick();
        check("post_init_b", 32'(if_b.cnt), 77);
        check("post_init_s", 32'(if_s.cnt), 2);
        load = 1'b0;

        // Random traffic against the model.
        repeat (300) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            we   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) dir = ~dir;
            lv_s = 3'($urandom);
            lv_b = 10'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
